// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and lane extract/merge helpers for load_store_unit.
// Defining LSU_MISALIGN_TRAP_EN makes misaligned halfword/word accesses fault.
package lsu_pkg;
   localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      return f3 == F3_B  ? {{24{b[7]}}, b} :
             f3 == F3_BU ? {24'h0, b} :
             f3 == F3_H  ? {{16{h[15]}}, h} :
             f3 == F3_HU ? {16'h0, h} : word;
   endfunction
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] m;
      m = word;
      if (f3 == F3_B) m[{off, 3'b000} +: 8] = wdata[7:0];
      else if (f3 == F3_H) m[{off[1], 4'b0000} +: 16] = wdata[15:0];
      else m = wdata;
      return m;
   endfunction
   function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      bad = we ? (f3 > F3_W) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef LSU_MISALIGN_TRAP_EN
      bad = bad || (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'b00);
`endif
      return bad;
   endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: merges store data into, and extracts extended load data from, a 32-bit word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   output logic [31:0] merged_o,
   output logic [31:0] extracted_o
);
   assign merged_o    = lane_merge(word_i, wdata_i, funct3_i, off_i);
   assign extracted_o = lane_extract(word_i, funct3_i, off_i);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store initiator with read-modify-write sub-word stores.
// Misaligned-access faulting is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_fault_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   input  logic [31:0]       mem_rdata_i
);
   state_e            state_q;
   logic              we_q, fault_q, req_bad;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, word_q, rdata_q, merged, extracted;

   // READ works on the live memory word; WRITE merges into the word captured during READ
   lsu_byte_lane u_lane (
      .word_i      (state_q == READ ? mem_rdata_i : word_q),
      .wdata_i     (wdata_q),
      .funct3_i    (funct3_q),
      .off_i       (off_q),
      .merged_o    (merged),
      .extracted_o (extracted)
   );

   assign req_bad = is_fault(req_we_i, req_funct3_i, req_addr_i[1:0]);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         fault_q  <= 1'b0;
         funct3_q <= '0;
         off_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid_i) begin
               we_q     <= req_we_i;
               funct3_q <= req_funct3_i;
               off_q    <= req_addr_i[1:0];
               addr_q   <= {req_addr_i[ADDR_W-1:2], 2'b00};
               wdata_q  <= req_wdata_i;
               rdata_q  <= '0;
               fault_q  <= req_bad;
               state_q  <= req_bad ? RESP : (req_we_i && req_funct3_i == F3_W) ? WRITE : READ;
            end
            READ: begin
               word_q  <= mem_rdata_i;
               rdata_q <= we_q ? '0 : extracted;
               state_q <= we_q ? WRITE : RESP;
            end
            WRITE: state_q <= RESP;
            default: begin
               rdata_q <= '0;
               fault_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o    = state_q == IDLE;
   assign resp_valid_o   = state_q == RESP;
   assign resp_rdata_o   = rdata_q;
   assign resp_fault_o   = fault_q;
   assign mem_addr_o     = addr_q;
   assign mem_read_en_o  = state_q == READ;
   assign mem_write_en_o = state_q == WRITE;
   assign mem_wdata_o    = state_q == WRITE ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plan plus random traffic checked against a byte-arithmetic memory model.
module tb_load_store_unit;
   logic        clk = 0, rst_n = 0;
   logic        req_valid = 0, req_we = 0;
   logic [2:0]  req_funct3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, resp_valid, resp_fault, mem_read_en, mem_write_en;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [16];
   logic [31:0] ref_mem [16];
   int          n_checks = 0, n_fail = 0;
   logic [31:0] last_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_fault_o(resp_fault),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_en_o(mem_read_en),
      .mem_write_en_o(mem_write_en), .mem_rdata_i(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk) if (mem_write_en) mem[mem_addr[5:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-granular little-endian arithmetic on a word array
   task automatic model(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                        output logic [31:0] er, output logic ef, output int elat, output int erd, output int ewr);
      int size, pos;
      logic [31:0] w, mask, v;
      size = f3[1:0] == 0 ? 1 : f3[1:0] == 1 ? 2 : 4;
      ef = we ? (f3 > 2) : (f3 == 3 || f3 > 5);
`ifdef LSU_MISALIGN_TRAP_EN
      if (a % size != 0) ef = 1;
`endif
      pos = (a % 4) / size * size;
      mask = size == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
      w = ref_mem[a / 4];
      er = 0; elat = 1; erd = 0; ewr = 0;
      if (!ef) begin
         if (!we) begin
            v = (w >> (8 * pos)) & mask;
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
            er = v; elat = 2; erd = 1;
         end else begin
            ref_mem[a / 4] = (w & ~(mask << (8 * pos))) | ((wd & mask) << (8 * pos));
            ewr = 1; erd = size < 4 ? 1 : 0; elat = size < 4 ? 3 : 2;
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd);
      logic [31:0] er; logic ef; int elat, erd, ewr, cyc, rd, wr; bit got;
      model(we, f3, a, wd, er, ef, elat, erd, ewr);
      @(negedge clk);
      check("ready_before_req", {31'b0, req_ready}, 1);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1 req_valid = 0;
      cyc = 1; rd = 0; wr = 0; got = 0;
      while (cyc < 10 && !got) begin
         @(negedge clk);
         rd += mem_read_en; wr += mem_write_en;
         if (resp_valid) begin
            got = 1;
            last_rdata = resp_rdata;
            check("resp_rdata", resp_rdata, er);
            check("resp_fault", {31'b0, resp_fault}, {31'b0, ef});
            check("resp_latency", cyc, elat);
         end else begin
            @(posedge clk); cyc++;
         end
      end
      if (!got) check("resp_timeout", 0, 1);
      check("read_cycles", rd, erd);
      check("write_cycles", wr, ewr);
      check("mem_word", mem[a / 4], ref_mem[a / 4]);
   endtask

   initial begin
      int p1, p2, np;
      logic [2:0] f3s [8] = '{0, 1, 2, 4, 5, 0, 2, 3};
      for (int i = 0; i < 16; i++) begin mem[i] = 32'hDEAD_BEEF; ref_mem[i] = 32'hDEAD_BEEF; end
      #12;
      check("rst_ready", {31'b0, req_ready}, 1);
      check("rst_resp_valid", {31'b0, resp_valid}, 0);
      check("rst_enables", {30'b0, mem_read_en, mem_write_en}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_rdata", resp_rdata, 0);
      @(negedge clk); rst_n = 1;

      do_req(0, 2, 'h8, 0);                check("lw_8", last_rdata, 32'hDEAD_BEEF);
      do_req(1, 0, 'h9, 32'h12);           check("sb_9_word", mem[2], 32'hDEAD_12EF);
      do_req(0, 4, 'h9, 0);                check("lbu_9", last_rdata, 32'h0000_0012);
      do_req(0, 0, 'hB, 0);                check("lb_b", last_rdata, 32'hFFFF_FFDE);
      do_req(1, 1, 'h6, 32'hA5A5_5A5A);    check("sh_6_word", mem[1], 32'h5A5A_BEEF);
      do_req(0, 1, 'h6, 0);                check("lh_6", last_rdata, 32'h0000_5A5A);
      do_req(0, 5, 'h4, 0);                check("lhu_4", last_rdata, 32'h0000_BEEF);
      do_req(1, 2, 'h2, 32'h1122_3344);
`ifdef LSU_MISALIGN_TRAP_EN
      check("sw_mis_word", mem[0], 32'hDEAD_BEEF);
`else
      check("sw_mis_word", mem[0], 32'h1122_3344);
`endif
      do_req(0, 3, 'h0, 0);                check("bad_f3_rdata", last_rdata, 0);

      // Reset in the WRITE cycle of SB 0x0: no write, no response
      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 0; req_addr = 0; req_wdata = 32'h77;
      @(posedge clk); #1 req_valid = 0;
      @(negedge clk); check("rmw_read", {31'b0, mem_read_en}, 1);
      @(negedge clk); check("rmw_write", {31'b0, mem_write_en}, 1);
      rst_n = 0; #1;
      check("rst_write_drop", {31'b0, mem_write_en}, 0);
      @(negedge clk); rst_n = 1;
      np = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); np += resp_valid; end
      check("rst_no_resp", np, 0);
      check("rst_ready_after", {31'b0, req_ready}, 1);
      check("rst_no_write", mem[0], ref_mem[0]);

      // req_valid held high: second acceptance only after RESP
      @(negedge clk);
      req_valid = 1; req_we = 0; req_funct3 = 2; req_addr = 'h8;
      p1 = 0; p2 = 0; np = 0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 1) check("busy_ready", {31'b0, req_ready}, 0);
         if (resp_valid) begin np++; if (np == 1) p1 = c; else p2 = c; end
      end
      req_valid = 0;
      check("busy_pulses", np, 2);
      check("busy_first", p1, 2);
      check("busy_second", p2, 5);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         logic [2:0] f3; logic we;
         we = 1'($urandom_range(0, 1));
         f3 = f3s[$urandom_range(0, 7)];
         if (we && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
         do_req(we, f3, $urandom_range(0, 63), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
